// File: rtl/mc_datapath.sv
// Parametrised multicore datapath: register file, bus mux, ALU and Z flag,
// plus a request/grant/valid handshake toward the shared-memory arbiter.
module mc_datapath #(
  parameter int REG_WIDTH = 12,
  parameter int INS_WIDTH = 8,
  parameter int NUM_GP    = 4,
  parameter int SEL_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SEL_W-1:0]     busSel,
  input  logic [NUM_GP-1:0]    gpWrEn,
  input  logic [NUM_GP-1:0]    gpInc,
  input  logic                 arWrEn,
  input  logic                 rWrEn,
  input  logic                 irWrEn,
  input  logic                 acWrEn,
  input  logic                 pcWrEn,
  input  logic                 pcInc,
  input  logic [2:0]           aluOp,
  input  logic                 zWrEn,
  input  logic                 memRd,
  input  logic                 memWr,
  input  logic [INS_WIDTH-1:0] insData,
  output logic [INS_WIDTH-1:0] insAddr,
  output logic                 memReq,
  output logic                 memWe,
  output logic [REG_WIDTH-1:0] memAddr,
  output logic [REG_WIDTH-1:0] memWData,
  input  logic                 memGnt,
  input  logic                 memRValid,
  input  logic [REG_WIDTH-1:0] memRData,
  output logic                 stall,
  output logic                 zFlag,
  output logic [REG_WIDTH-1:0] acOut
);

  localparam logic [REG_WIDTH-1:0] REG_ONE = REG_WIDTH'(1);
  localparam logic [INS_WIDTH-1:0] INS_ONE = INS_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, REQ, RWAIT} mem_state_t;

  mem_state_t state_q, state_d;

  logic [REG_WIDTH-1:0] ar_q, r_q, ac_q, mdr_q;
  logic [INS_WIDTH-1:0] pc_q, ir_q;
  logic [REG_WIDTH-1:0] gp_q [NUM_GP];
  logic                 z_q;
  logic                 we_q;
  logic [REG_WIDTH-1:0] addr_q, wdata_q;

  logic [REG_WIDTH-1:0] ir_ext;
  logic [REG_WIDTH-1:0] bus;
  logic [REG_WIDTH-1:0] alu_res;
  logic                 issue;
  logic                 mdr_load;

  always_comb begin
    ir_ext = '0;
    ir_ext[INS_WIDTH-1:0] = ir_q;
  end

  // Unused select codes fall through to zero.
  always_comb begin
    bus = '0;
    case (busSel)
      SEL_W'(0): bus = mdr_q;
      SEL_W'(1): bus = r_q;
      SEL_W'(2): bus = ir_ext;
      SEL_W'(3): bus = ac_q;
      default: begin
        for (int i = 0; i < NUM_GP; i++) begin
          if (busSel == SEL_W'(i + 4)) bus = gp_q[i];
        end
      end
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (aluOp)
      3'd0: alu_res = bus;
      3'd1: alu_res = ac_q + bus;
      3'd2: alu_res = ac_q - bus;
      3'd3: alu_res = ac_q * bus;
      3'd4: alu_res = ac_q + REG_ONE;
      3'd5: alu_res = ac_q - REG_ONE;
      3'd6: alu_res = '0;
      3'd7: alu_res = ac_q;
    endcase
  end

  assign stall = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ar_q <= '0;
      r_q  <= '0;
      ac_q <= '0;
      pc_q <= '0;
      ir_q <= '0;
      z_q  <= 1'b0;
      for (int i = 0; i < NUM_GP; i++) gp_q[i] <= '0;
    end else if (!stall) begin
      if (arWrEn) ar_q <= bus;
      if (rWrEn)  r_q  <= bus;
      if (irWrEn) ir_q <= insData;
      if (acWrEn) ac_q <= alu_res;
      if (zWrEn)  z_q  <= (alu_res == '0);
      if (pcWrEn)     pc_q <= ir_q;
      else if (pcInc) pc_q <= pc_q + INS_ONE;
      for (int i = 0; i < NUM_GP; i++) begin
        if (gpWrEn[i])     gp_q[i] <= bus;
        else if (gpInc[i]) gp_q[i] <= gp_q[i] + REG_ONE;
      end
    end
  end

  // Handshake sequencing; only IDLE accepts a new access.
  always_comb begin
    state_d  = state_q;
    issue    = 1'b0;
    mdr_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (memWr || memRd) begin
          issue   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (memGnt) state_d = we_q ? IDLE : RWAIT;
      end
      RWAIT: begin
        if (memRValid) begin
          mdr_load = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mdr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (issue) begin
        addr_q  <= ar_q;
        wdata_q <= r_q;
        we_q    <= memWr;
      end
      if (mdr_load) mdr_q <= memRData;
    end
  end

  assign memReq   = (state_q == REQ);
  assign memWe    = we_q;
  assign memAddr  = addr_q;
  assign memWData = wdata_q;
  assign insAddr  = pc_q;
  assign zFlag    = z_q;
  assign acOut    = ac_q;

endmodule

// File: tb/tb_mc_datapath.sv
// Directed bench for mc_datapath: ALU/Z, load/increment priority and wrap,
// write/read handshakes, ignored events and asynchronous reset.
module tb_mc_datapath;

  logic        clk;
  logic        rst;
  logic [3:0]  busSel;
  logic [3:0]  gpWrEn;
  logic [3:0]  gpInc;
  logic        arWrEn, rWrEn, irWrEn, acWrEn;
  logic        pcWrEn, pcInc;
  logic [2:0]  aluOp;
  logic        zWrEn;
  logic        memRd, memWr;
  logic [7:0]  insData;
  logic [7:0]  insAddr;
  logic        memReq, memWe;
  logic [11:0] memAddr, memWData;
  logic        memGnt, memRValid;
  logic [11:0] memRData;
  logic        stall;
  logic        zFlag;
  logic [11:0] acOut;

  int num_checks;
  int num_passed;

  mc_datapath #(
    .REG_WIDTH(12), .INS_WIDTH(8), .NUM_GP(4), .SEL_W(4)
  ) dut (
    .clk(clk), .rst(rst), .busSel(busSel), .gpWrEn(gpWrEn), .gpInc(gpInc),
    .arWrEn(arWrEn), .rWrEn(rWrEn), .irWrEn(irWrEn), .acWrEn(acWrEn),
    .pcWrEn(pcWrEn), .pcInc(pcInc), .aluOp(aluOp), .zWrEn(zWrEn),
    .memRd(memRd), .memWr(memWr), .insData(insData), .insAddr(insAddr),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
    .memGnt(memGnt), .memRValid(memRValid), .memRData(memRData),
    .stall(stall), .zFlag(zFlag), .acOut(acOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    num_checks++;
    if (actual === expected) num_passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  task automatic clearCtl();
    busSel = '0; gpWrEn = '0; gpInc = '0;
    arWrEn = 0; rWrEn = 0; irWrEn = 0; acWrEn = 0;
    pcWrEn = 0; pcInc = 0; aluOp = '0; zWrEn = 0;
    memRd = 0; memWr = 0; memGnt = 0; memRValid = 0;
  endtask

  // Commit the controls set up for this cycle, then leave the next cycle clean.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    clearCtl();
  endtask

  task automatic loadAcFromBus(input logic [3:0] sel, input logic upd_z);
    busSel = sel; aluOp = 3'd0; acWrEn = 1; zWrEn = upd_z;
    applyStimulus();
  endtask

  // Build an arbitrary 12-bit AC value from the 8-bit IR: hi*16 + lo.
  task automatic setAc(input logic [11:0] v);
    insData = v[11:4]; irWrEn = 1;
    applyStimulus();
    busSel = 4'd2; aluOp = 3'd0; acWrEn = 1; insData = 8'h10; irWrEn = 1;
    applyStimulus();
    busSel = 4'd2; aluOp = 3'd3; acWrEn = 1; insData = {4'h0, v[3:0]}; irWrEn = 1;
    applyStimulus();
    busSel = 4'd2; aluOp = 3'd1; acWrEn = 1;
    applyStimulus();
  endtask

  initial begin
    num_checks = 0;
    num_passed = 0;
    rst = 1;
    clearCtl();
    insData = '0;
    memRData = '0;
    #2;
    checkOutput("rst_memReq",   32'(memReq),   32'h0);
    checkOutput("rst_memWe",    32'(memWe),    32'h0);
    checkOutput("rst_memAddr",  32'(memAddr),  32'h0);
    checkOutput("rst_memWData", 32'(memWData), 32'h0);
    checkOutput("rst_stall",    32'(stall),    32'h0);
    checkOutput("rst_insAddr",  32'(insAddr),  32'h0);
    checkOutput("rst_zFlag",    32'(zFlag),    32'h0);
    checkOutput("rst_acOut",    32'(acOut),    32'h0);
    @(posedge clk);
    #1;
    rst = 0;

    // GP[1] = 1, AC = 0xFFF, then AC + GP[1] wraps to zero
    insData = 8'h01; irWrEn = 1; applyStimulus();
    busSel = 4'd2; gpWrEn = 4'b0010; applyStimulus();
    setAc(12'hFFF);
    checkOutput("setAc_fff", 32'(acOut), 32'hFFF);
    busSel = 4'd5; aluOp = 3'd1; acWrEn = 1; zWrEn = 1; applyStimulus();
    checkOutput("add_wrap_ac", 32'(acOut), 32'h000);
    checkOutput("add_wrap_z",  32'(zFlag), 32'h1);

    // GP[0] = 0x041, AC = 0x040, multiply keeps low bits
    setAc(12'h041);
    busSel = 4'd3; gpWrEn = 4'b0001; applyStimulus();
    setAc(12'h040);
    busSel = 4'd4; aluOp = 3'd3; acWrEn = 1; zWrEn = 1; applyStimulus();
    checkOutput("mul_ac", 32'(acOut), 32'h040);
    checkOutput("mul_z",  32'(zFlag), 32'h0);
    busSel = 4'd4; aluOp = 3'd2; acWrEn = 1; applyStimulus();
    checkOutput("sub_ac", 32'(acOut), 32'hFFF);
    aluOp = 3'd5; acWrEn = 1; applyStimulus();
    checkOutput("dec_ac", 32'(acOut), 32'hFFE);
    aluOp = 3'd7; acWrEn = 1; busSel = 4'd4; applyStimulus();
    checkOutput("hold_ac", 32'(acOut), 32'hFFE);
    aluOp = 3'd4; acWrEn = 1; applyStimulus();
    checkOutput("inc_ac", 32'(acOut), 32'hFFF);
    aluOp = 3'd6; acWrEn = 1; zWrEn = 1; applyStimulus();
    checkOutput("clr_ac", 32'(acOut), 32'h000);
    checkOutput("clr_z",  32'(zFlag), 32'h1);

    // Load beats increment; increments wrap
    setAc(12'h123);
    busSel = 4'd3; gpWrEn = 4'b0100; gpInc = 4'b0100; applyStimulus();
    loadAcFromBus(4'd6, 1'b0);
    checkOutput("gp2_load_prio", 32'(acOut), 32'h123);
    setAc(12'hFFF);
    busSel = 4'd3; gpWrEn = 4'b1000; applyStimulus();
    gpInc = 4'b1000; applyStimulus();
    loadAcFromBus(4'd7, 1'b0);
    checkOutput("gp3_wrap", 32'(acOut), 32'h000);
    insData = 8'hFF; irWrEn = 1; applyStimulus();
    pcWrEn = 1; applyStimulus();
    checkOutput("pc_load", 32'(insAddr), 32'hFF);
    pcInc = 1; applyStimulus();
    checkOutput("pc_wrap", 32'(insAddr), 32'h00);
    insData = 8'h33; irWrEn = 1; applyStimulus();
    pcWrEn = 1; pcInc = 1; applyStimulus();
    checkOutput("pc_load_prio", 32'(insAddr), 32'h33);

    // Write handshake with three ungranted cycles
    setAc(12'h010);
    busSel = 4'd3; arWrEn = 1; applyStimulus();
    setAc(12'h0AB);
    busSel = 4'd3; rWrEn = 1; applyStimulus();
    memWr = 1; gpInc = 4'b0010; applyStimulus();
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("wr_memReq_%0d", i),   32'(memReq),   32'h1);
      checkOutput($sformatf("wr_stall_%0d", i),    32'(stall),    32'h1);
      checkOutput($sformatf("wr_memAddr_%0d", i),  32'(memAddr),  32'h010);
      checkOutput($sformatf("wr_memWData_%0d", i), 32'(memWData), 32'h0AB);
      checkOutput($sformatf("wr_memWe_%0d", i),    32'(memWe),    32'h1);
      gpInc = 4'b0001;
      memGnt = (i == 3);
      applyStimulus();
    end
    checkOutput("wr_done_memReq", 32'(memReq), 32'h0);
    checkOutput("wr_done_stall",  32'(stall),  32'h0);
    loadAcFromBus(4'd4, 1'b0);
    checkOutput("gp0_frozen", 32'(acOut), 32'h041);
    loadAcFromBus(4'd5, 1'b0);
    checkOutput("gp1_issue_inc", 32'(acOut), 32'h002);

    // Read handshake: grant next cycle, data two cycles after the grant
    memRd = 1; applyStimulus();
    checkOutput("rd_memReq", 32'(memReq), 32'h1);
    checkOutput("rd_memWe",  32'(memWe),  32'h0);
    checkOutput("rd_stall",  32'(stall),  32'h1);
    memGnt = 1; applyStimulus();
    checkOutput("rd_wait_memReq", 32'(memReq), 32'h0);
    checkOutput("rd_wait_stall",  32'(stall),  32'h1);
    busSel = 4'd0; acWrEn = 1; applyStimulus();
    checkOutput("rd_wait2_stall", 32'(stall), 32'h1);
    memRValid = 1; memRData = 12'h5A5; busSel = 4'd0; acWrEn = 1; applyStimulus();
    checkOutput("rd_done_stall", 32'(stall), 32'h0);
    checkOutput("rd_ac_frozen",  32'(acOut), 32'h002);
    loadAcFromBus(4'd0, 1'b0);
    checkOutput("rd_mdr", 32'(acOut), 32'h5A5);

    // Ignored events during REQ and in IDLE
    memRd = 1; applyStimulus();
    memRd = 1; memRValid = 1; memRData = 12'h333; applyStimulus();
    checkOutput("req_ign_memReq", 32'(memReq), 32'h1);
    checkOutput("req_ign_stall",  32'(stall),  32'h1);
    memGnt = 1; applyStimulus();
    applyStimulus();
    checkOutput("rwait_hold_stall",  32'(stall),  32'h1);
    checkOutput("rwait_hold_memReq", 32'(memReq), 32'h0);
    memRValid = 1; memRData = 12'h6C6; applyStimulus();
    checkOutput("rd2_done_stall", 32'(stall), 32'h0);
    memRValid = 1; memRData = 12'h777; memGnt = 1; applyStimulus();
    checkOutput("idle_ign_memReq", 32'(memReq), 32'h0);
    checkOutput("idle_ign_stall",  32'(stall),  32'h0);
    loadAcFromBus(4'd0, 1'b1);
    checkOutput("idle_ign_mdr", 32'(acOut), 32'h6C6);
    checkOutput("mdr_z",        32'(zFlag), 32'h0);
    busSel = 4'd8; aluOp = 3'd0; acWrEn = 1; applyStimulus();
    checkOutput("bus_sel8", 32'(acOut), 32'h000);
    loadAcFromBus(4'd0, 1'b0);
    loadAcFromBus(4'd15, 1'b1);
    checkOutput("bus_sel15_ac", 32'(acOut), 32'h000);
    checkOutput("bus_sel15_z",  32'(zFlag), 32'h1);

    // Asynchronous reset while waiting for read data
    memRd = 1; applyStimulus();
    memGnt = 1; applyStimulus();
    checkOutput("pre_rst_stall", 32'(stall), 32'h1);
    #2;
    rst = 1;
    #1;
    checkOutput("arst_memReq",   32'(memReq),   32'h0);
    checkOutput("arst_stall",    32'(stall),    32'h0);
    checkOutput("arst_zFlag",    32'(zFlag),    32'h0);
    checkOutput("arst_acOut",    32'(acOut),    32'h0);
    checkOutput("arst_insAddr",  32'(insAddr),  32'h0);
    checkOutput("arst_memAddr",  32'(memAddr),  32'h0);
    checkOutput("arst_memWData", 32'(memWData), 32'h0);
    checkOutput("arst_memWe",    32'(memWe),    32'h0);
    @(posedge clk);
    #1;
    rst = 0;
    clearCtl();
    loadAcFromBus(4'd0, 1'b0);
    checkOutput("arst_mdr", 32'(acOut), 32'h000);
    checkOutput("arst_after_stall", 32'(stall), 32'h0);

    $display("%0d/%0d checks passed", num_passed, num_checks);
    $finish;
  end

endmodule
